// File: rtl/pack_pkg.sv
// Shared definitions for the 15-bit coefficient packer and unpacker.
// Word/coefficient geometry, frame sizes, lane type and security-level encoding.
// Occupancy constants are pre-sized to the bit-counter width so comparisons stay width-exact.
package pack_pkg;

   localparam int DATA_W    = 64;               // packed and unpacked word width
   localparam int COEF_W    = 15;               // significant bits per coefficient
   localparam int LANES     = 4;                // coefficients per unpacked word
   localparam int LANE_W    = DATA_W / LANES;   // 16-bit lane
   localparam int CHUNK_W   = LANES * COEF_W;   // 60 bits consumed per output word
   localparam int FRAME_IN  = 15;               // packed words per frame
   localparam int FRAME_OUT = 16;               // unpacked words per frame
   localparam int BUF_W     = 2 * DATA_W;       // bit FIFO depth
   localparam int CNT_W     = 8;                // occupancy counter width

   localparam logic [CNT_W-1:0] CHUNK_BITS = CNT_W'(CHUNK_W);
   localparam logic [CNT_W-1:0] WORD_BITS  = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] MAX_BITS   = CNT_W'(BUF_W);

   typedef logic [LANE_W-1:0] lane_t;
   typedef logic [COEF_W-1:0] coef_t;

   typedef enum logic [1:0] {
      SEC_PACKED = 2'd0,
      SEC_LVL1   = 2'd1,
      SEC_LVL2   = 2'd2,
      SEC_LVL3   = 2'd3
   } sec_lvl_e;

   // Any non-zero security level routes data around the (un)packer.
   function automatic logic is_bypass(input logic [1:0] lvl);
      return lvl != SEC_PACKED;
   endfunction

endpackage

// File: rtl/pack_unset_if.sv
// Packed-in / unpacked-out stream bundle for pack_unset.
// master: upstream source + downstream sink (drives packIn*, packOut_rdy).
// slave:  the unpacker (drives packIn_rdy, packOut*).
interface pack_unset_if;
   import pack_pkg::*;

   logic [DATA_W-1:0] packIn;
   logic              packIn_val;
   logic              packIn_rdy;
   logic [DATA_W-1:0] packOut;
   logic              packOut_val;
   logic              packOut_rdy;

   modport master (
      output packIn, packIn_val, packOut_rdy,
      input  packIn_rdy, packOut, packOut_val
   );

   modport slave (
      input  packIn, packIn_val, packOut_rdy,
      output packIn_rdy, packOut, packOut_val
   );

endinterface

// File: rtl/pack_unset_lane.sv
// Widens one 15-bit coefficient to a 16-bit lane; purely combinational.
// Ports: coef (15-bit coefficient in), lane (16-bit lane out).
// UNPACK_SIGN_EXT_EN defined: two's-complement sign extension; otherwise zero extension.
module pack_unset_lane
   import pack_pkg::*;
(
   input  coef_t coef,
   output lane_t lane
);

`ifdef UNPACK_SIGN_EXT_EN
   assign lane = {coef[COEF_W-1], coef};
`else
   assign lane = {1'b0, coef};
`endif

endmodule

// File: rtl/pack_unset.sv
// Unpacks 15 dense words of 4x15-bit coefficients into 16 words of 4x16-bit lanes;
// output valid combinationally once 60 bits are buffered (first output the cycle after the first input).
// Ports: clk, rstn (sync active-low), sec_lvl (0 = unpack, else bypass), bus (slave side of pack_unset_if).
// Build option UNPACK_SIGN_EXT_EN selects sign extension of each lane (default zero extension).
module pack_unset
   import pack_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic [1:0] sec_lvl,
   pack_unset_if.slave bus
);

   // MSB-aligned bit FIFO: the oldest received bit sits at buffer[BUF_W-1].
   // Bits below the occupied region are always zero so new words can be OR-ed in.
   logic [BUF_W-1:0]   buffer;
   logic [BUF_W-1:0]   buf_next;
   logic [BUF_W-1:0]   wr_word;
   logic [CNT_W-1:0]   buf_bits;
   logic [CNT_W-1:0]   bits_after;
   logic [CNT_W-1:0]   cnt_next;
   logic               mode_q;        // 1 = bypass

   logic               unp_val;
   logic               unp_rdy;
   logic               out_fire_unp;
   logic               in_fire;
   logic [CHUNK_W-1:0] chunk;
   logic [DATA_W-1:0]  unp_word;

   // Oldest 60 bits; coefficient 0 of the chunk (first received) lands in lane 3.
   assign chunk = buffer[BUF_W-1 -: CHUNK_W];

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         pack_unset_lane u_lane (
            .coef (chunk[COEF_W*gi +: COEF_W]),
            .lane (unp_word[LANE_W*gi +: LANE_W])
         );
      end
   endgenerate

   // Unpack-side handshake. Ready looks at occupancy after this cycle's pop,
   // giving a combinational packOut_rdy -> packIn_rdy path.
   always_comb begin
      unp_val      = (buf_bits >= CHUNK_BITS);
      out_fire_unp = unp_val & bus.packOut_rdy & ~mode_q;
      bits_after   = out_fire_unp ? (buf_bits - CHUNK_BITS) : buf_bits;
      unp_rdy      = (bits_after <= WORD_BITS);
   end

   // Output select: bypass is a straight wire-through of data and handshake.
   always_comb begin
      if (mode_q) begin
         bus.packOut     = bus.packIn;
         bus.packOut_val = bus.packIn_val;
         bus.packIn_rdy  = bus.packOut_rdy;
      end else begin
         bus.packOut     = unp_word;
         bus.packOut_val = unp_val;
         bus.packIn_rdy  = unp_rdy;
      end
   end

   assign in_fire = bus.packIn_val & bus.packIn_rdy;

   // Pop first, then append the new word directly below the surviving bits.
   always_comb begin
      wr_word  = {bus.packIn, {DATA_W{1'b0}}} >> bits_after;
      buf_next = out_fire_unp ? (buffer << CHUNK_W) : buffer;
      cnt_next = bits_after;
      if (in_fire && !mode_q) begin
         buf_next = buf_next | wr_word;
         cnt_next = bits_after + WORD_BITS;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         buffer   <= '0;
         buf_bits <= '0;
         mode_q   <= 1'b0;
      end else begin
         if (!mode_q) begin
            buffer   <= buf_next;
            buf_bits <= cnt_next;
         end
         // Mode only changes between frames, so a frame is never split across modes.
         if (buf_bits == '0 && !in_fire) begin
            mode_q <= is_bypass(sec_lvl);
         end
      end
   end

   // Occupancy peaks at exactly 128 (e.g. 64 held under backpressure plus one more
   // word admitted at bits_after == 64); ready gating makes anything above that impossible.
   a_buf_bound: assert property (@(posedge clk) disable iff (!rstn) buf_bits <= MAX_BITS);

endmodule

// File: tb/tb_pack_unset.sv
module tb_pack_unset;
   import pack_pkg::*;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [1:0] sec_lvl = 2'd0;

   pack_unset_if bus();

   pack_unset dut (
      .clk     (clk),
      .rstn    (rstn),
      .sec_lvl (sec_lvl),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   logic [63:0] sb[$];
   int rdy_mode = 0;     // 0 always ready, 1 random, 2 held low
   int in_cnt = 0;
   int stall_cnt = 0;

   logic [63:0] frm  [FRAME_IN];
   logic [63:0] orig [FRAME_OUT];

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic lane_t ext(input logic [14:0] c);
`ifdef UNPACK_SIGN_EXT_EN
      return {c[14], c};
`else
      return {1'b0, c};
`endif
   endfunction

   // Reference: treat the frame as one 960-bit string, cut 15-bit coefficients in order,
   // four per output word with the earliest in the top lane.
   function automatic void unpack_model();
      logic [959:0] big;
      logic [63:0]  w;
      for (int i = 0; i < FRAME_IN; i++) big[959-64*i -: 64] = frm[i];
      for (int k = 0; k < FRAME_OUT; k++) begin
         for (int l = 0; l < 4; l++) begin
            int j;
            j = 4*k + (3 - l);
            w[16*l +: 16] = ext(big[959-15*j -: 15]);
         end
         sb.push_back(w);
      end
   endfunction

   // Golden packer: concatenate the low 15 bits of each lane (lane 3 first) and slice 64-bit words.
   // The round trip must return the originals with bit 15 of each lane rebuilt by extension.
   function automatic void pack_model_and_expect();
      logic [959:0] big;
      logic [63:0]  w;
      for (int k = 0; k < FRAME_OUT; k++) begin
         for (int l = 3; l >= 0; l--) begin
            int j;
            j = 4*k + (3 - l);
            big[959-15*j -: 15] = orig[k][16*l +: 15];
         end
      end
      for (int i = 0; i < FRAME_IN; i++) frm[i] = big[959-64*i -: 64];
      for (int k = 0; k < FRAME_OUT; k++) begin
         for (int l = 0; l < 4; l++) w[16*l +: 16] = ext(orig[k][16*l +: 15]);
         sb.push_back(w);
      end
   endfunction

   // Monitor / scoreboard: every output handshake pops one expected word.
   always @(negedge clk) begin
      if (rstn && bus.packOut_val && bus.packOut_rdy) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_out: got %h expected no output", bus.packOut);
         end else begin
            check64("out_word", bus.packOut, sb.pop_front());
         end
      end
      if (rstn && bus.packIn_val && bus.packIn_rdy) in_cnt++;
      if (rstn && bus.packIn_val && !bus.packIn_rdy) stall_cnt++;
   end

   // Downstream ready driver.
   initial begin
      bus.packOut_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.packOut_rdy = 1'b1;
            1:       bus.packOut_rdy = ($urandom_range(3) != 0);
            default: bus.packOut_rdy = 1'b0;
         endcase
      end
   end

   task automatic send(input logic [63:0] w);
      int t;
      t = 0;
      bus.packIn     = w;
      bus.packIn_val = 1'b1;
      @(negedge clk);
      while (!bus.packIn_rdy && t < 300) begin
         t++;
         @(negedge clk);
      end
      if (!bus.packIn_rdy) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: got packIn_rdy=0 for %0d cycles expected acceptance", t);
      end
      @(posedge clk);
      #1;
      bus.packIn_val = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input bit gaps);
      for (int i = 0; i < FRAME_IN; i++) begin
         send(frm[i]);
         if (gaps) idle($urandom_range(2));
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 2000) begin
         @(posedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d words outstanding expected 0", sb.size());
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_frame();
      for (int i = 0; i < FRAME_IN; i++) frm[i] = {$urandom, $urandom};
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish within time limit");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] hold_dat;
      logic        hold_val;
      logic [63:0] ones_exp;
      logic [63:0] bw;
      int          base;

      bus.packIn     = '0;
      bus.packIn_val = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;

      // Reset state
      check64("rst_out_val", 64'(bus.packOut_val), 64'd0);
      check64("rst_in_rdy", 64'(bus.packIn_rdy), 64'd1);
      check64("rst_out_dat", bus.packOut, 64'd0);

      // All-ones frame
`ifdef UNPACK_SIGN_EXT_EN
      ones_exp = 64'hFFFF_FFFF_FFFF_FFFF;
`else
      ones_exp = 64'h7FFF_7FFF_7FFF_7FFF;
`endif
      for (int i = 0; i < FRAME_IN; i++) frm[i] = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int k = 0; k < FRAME_OUT; k++) sb.push_back(ones_exp);
      send_frame(1'b0);
      drain();
      check64("ones_end_val", 64'(bus.packOut_val), 64'd0);
      check64("ones_end_rdy", 64'(bus.packIn_rdy), 64'd1);

      // Round trip through the golden packer, random gaps and backpressure
      rdy_mode = 1;
      for (int f = 0; f < 5; f++) begin
         for (int k = 0; k < FRAME_OUT; k++) orig[k] = {$urandom, $urandom};
         pack_model_and_expect();
         send_frame(1'b1);
         drain();
      end
      // Raw random frames against the bit-string model
      for (int f = 0; f < 3; f++) begin
         rand_frame();
         unpack_model();
         send_frame(1'b1);
         drain();
      end
      rdy_mode = 0;
      idle(1);

      // Continuous streaming of three frames: steady state admits 15 words per 16 cycles,
      // so the source sees packIn_rdy low once per frame after the first.
      stall_cnt = 0;
      for (int f = 0; f < 3; f++) begin
         rand_frame();
         unpack_model();
         send_frame(1'b0);
      end
      drain();
      check64("stream_stalls", 64'(stall_cnt), 64'd2);

      // Backpressure for 10 cycles mid-frame
      rand_frame();
      unpack_model();
      base = in_cnt;
      fork
         send_frame(1'b0);
         begin
            int t;
            t = 0;
            while (in_cnt < base + 4 && t < 200) begin
               @(negedge clk);
               t++;
            end
            rdy_mode = 2;
            @(posedge clk);
            @(negedge clk);
            hold_dat = bus.packOut;
            hold_val = bus.packOut_val;
            check64("bp_val_start", 64'(hold_val), 64'd1);
            repeat (9) begin
               @(negedge clk);
               check64("bp_val_hold", 64'(bus.packOut_val), 64'(hold_val));
               check64("bp_dat_hold", bus.packOut, hold_dat);
            end
            check64("bp_in_rdy", 64'(bus.packIn_rdy), 64'd0);
            rdy_mode = 0;
         end
      join
      drain();

      // Bypass with empty buffer
      sec_lvl = 2'd1;
      rdy_mode = 2;
      idle(3);
      for (int i = 0; i < 4; i++) begin
         bus.packIn     = {$urandom, $urandom};
         bus.packIn_val = i[0];
         @(negedge clk);
         check64("byp_dat", bus.packOut, bus.packIn);
         check64("byp_val", 64'(bus.packOut_val), 64'(i[0]));
         check64("byp_rdy", 64'(bus.packIn_rdy), 64'd0);
         @(posedge clk);
         #1;
      end
      bus.packIn_val = 1'b0;
      rdy_mode = 1;
      for (int i = 0; i < 6; i++) begin
         bw = {$urandom, $urandom};
         sb.push_back(bw);
         send(bw);
      end
      drain();

      // Back to unpack, then request bypass after 5 inputs: frame must finish unpacked
      sec_lvl = 2'd0;
      rdy_mode = 0;
      idle(3);
      rand_frame();
      unpack_model();
      for (int i = 0; i < 5; i++) send(frm[i]);
      sec_lvl = 2'd2;
      for (int i = 5; i < FRAME_IN; i++) send(frm[i]);
      drain();
      rdy_mode = 2;
      idle(3);
      bus.packIn     = {$urandom, $urandom};
      bus.packIn_val = 1'b1;
      @(negedge clk);
      check64("late_byp_dat", bus.packOut, bus.packIn);
      check64("late_byp_val", 64'(bus.packOut_val), 64'd1);
      @(posedge clk);
      #1;
      bus.packIn_val = 1'b0;
      sec_lvl = 2'd0;
      rdy_mode = 0;
      idle(3);

      // Reset mid-frame after 7 inputs
      rand_frame();
      unpack_model();
      for (int i = 0; i < 7; i++) send(frm[i]);
      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      sb.delete();
      check64("midrst_out_val", 64'(bus.packOut_val), 64'd0);
      check64("midrst_in_rdy", 64'(bus.packIn_rdy), 64'd1);
      check64("midrst_out_dat", bus.packOut, 64'd0);
      rand_frame();
      unpack_model();
      rdy_mode = 1;
      send_frame(1'b1);
      drain();
      rdy_mode = 0;
      idle(2);

      check64("sb_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
